fetch_align_buf: RTL and testbench

FETCH_ALIGN_BUF -- requirements
Module: fetch_align_buf

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_line_align.sv | 50 +++++
 rtl/fetch_align_buf.sv | 212 +++++++++++++++++++++
 tb/tb_fetch_align_buf.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch alignment buffer: entry layout,
// controller state encoding and a constant-safe clog2 helper.
package fetch_pkg;

    // One instruction-buffer entry: {valid, is_jump, pc[31:0], instr[31:0]}
    localparam int ENTRY_W         = 66;
    localparam int ENTRY_INSTR_LSB = 0;
    localparam int ENTRY_PC_LSB    = 32;
    localparam int ENTRY_JUMP_BIT  = 64;
    localparam int ENTRY_VALID_BIT = 65;

    // Request controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // no request outstanding
        ST_WAIT  = 2'd1,  // request outstanding, response wanted
        ST_DRAIN = 2'd2   // request outstanding, response to be discarded
    } fetch_state_e;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_line_align.sv
// Rotates an I-cache line so slot 0 holds the word at the fetch PC,
// attaches pc/valid/jump to every slot and counts how many slots are
// usable (stopping after the first predicted-taken jump).
module fetch_line_align
    import fetch_pkg::*;
#(
    parameter int FETCH_WIDTH = 4
) (
    input  logic [32*FETCH_WIDTH-1:0]      line_i,
    input  logic [31:0]                    pc_i,
    input  logic [FETCH_WIDTH-1:0]         vmask_i,
    input  logic [FETCH_WIDTH-1:0]         jmask_i,
    output logic [FETCH_WIDTH*ENTRY_W-1:0] entries_o,
    output logic [clog2(FETCH_WIDTH):0]    count_o
);

    localparam int OW = clog2(FETCH_WIDTH);
    localparam int PW = OW + 1;

    logic [OW-1:0] off;
    logic [PW-1:0] idx;
    logic [OW-1:0] word;
    logic          found;

    assign off = pc_i[OW+1:2];

    // Rotate/annotate each slot and find the truncation point
    always_comb begin
        entries_o = '0;
        count_o   = PW'(FETCH_WIDTH) - PW'(off);
        found     = 1'b0;
        idx       = '0;
        word      = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            idx = PW'(off) + PW'(i);
            if (idx < PW'(FETCH_WIDTH)) begin
                word = idx[OW-1:0];
                entries_o[i*ENTRY_W+ENTRY_VALID_BIT]     = vmask_i[word];
                entries_o[i*ENTRY_W+ENTRY_JUMP_BIT]      = jmask_i[word];
                entries_o[i*ENTRY_W+ENTRY_PC_LSB +: 32]  = pc_i + 32'(4 * i);
                entries_o[i*ENTRY_W+ENTRY_INSTR_LSB +: 32] = line_i[int'(word)*32 +: 32];
                if (!found && jmask_i[word]) begin
                    count_o = PW'(i + 1);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_align_buf.sv
// Fetch alignment buffer: issues one I-cache request at a time, aligns the
// returned line to the fetch PC and feeds the instruction buffer, holding
// lines the IB cannot yet absorb in a small circular skid buffer.
//
// Handshakes: a request transfers on a cycle where req_valid & req_ready
// are both high; req_ready never depends on req_valid. push_num entries
// are consumed by the IB in the cycle they are presented (ib_free bounds it).
module fetch_align_buf
    import fetch_pkg::*;
#(
    parameter int FETCH_WIDTH   = 4,
    parameter int IB_WIDTH_LOG2 = 4,
    parameter int SKID_LINES    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_pc,
    input  logic [FETCH_WIDTH-1:0]         req_vmask,
    input  logic [FETCH_WIDTH-1:0]         req_jmask,
    input  logic                           resp_valid,
    input  logic [32*FETCH_WIDTH-1:0]      resp_data,
    input  logic [IB_WIDTH_LOG2:0]         ib_free,
    output logic [clog2(FETCH_WIDTH):0]    push_num,
    output logic [FETCH_WIDTH*ENTRY_W-1:0] push_data,
    output logic [1:0]                     dbg_state
);

    localparam int OW  = clog2(FETCH_WIDTH);
    localparam int PW  = OW + 1;
    localparam int LW  = FETCH_WIDTH * ENTRY_W;
    localparam int SW  = (SKID_LINES > 1) ? clog2(SKID_LINES) : 1;
    localparam int OCW = clog2(SKID_LINES + 1);

    // Controller state and latched request metadata
    fetch_state_e           state_q;
    logic [31:0]            pc_q;
    logic [FETCH_WIDTH-1:0] vmask_q;
    logic [FETCH_WIDTH-1:0] jmask_q;

    // Skid buffer: per-line aligned entries, remaining count and read index
    logic [LW-1:0]  skid_line_q [SKID_LINES];
    logic [PW-1:0]  skid_cnt_q  [SKID_LINES];
    logic [PW-1:0]  skid_rd_q   [SKID_LINES];
    logic [SW-1:0]  hd_q;
    logic [SW-1:0]  tl_q;
    logic [OCW-1:0] occ_q;
    logic [OCW-1:0] occ_d;

    // Aligned response
    logic [LW-1:0] aln_entries;
    logic [PW-1:0] aln_n;

    // Head source selection
    logic [LW-1:0] head_line;
    logic [PW-1:0] head_rd;
    logic [PW-1:0] head_rem;

    logic          skid_ne;
    logic          resp_take;
    logic [PW-1:0] push_cnt;
    logic          pop;
    logic          wr;
    logic [PW-1:0] wr_rd;
    logic [PW-1:0] wr_cnt;
    logic          accept;
    logic [PW-1:0] rd_idx;

    fetch_line_align #(
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_align (
        .line_i    (resp_data),
        .pc_i      (pc_q),
        .vmask_i   (vmask_q),
        .jmask_i   (jmask_q),
        .entries_o (aln_entries),
        .count_o   (aln_n)
    );

    assign skid_ne   = (occ_q != '0);
    assign resp_take = (state_q == ST_WAIT) && resp_valid && !flush;
    assign dbg_state = state_q;

    // Older skid contents always drain before a newly arriving line
    always_comb begin
        head_line = '0;
        head_rd   = '0;
        head_rem  = '0;
        if (skid_ne) begin
            head_line = skid_line_q[hd_q];
            head_rd   = skid_rd_q[hd_q];
            head_rem  = skid_cnt_q[hd_q];
        end else if (resp_take) begin
            head_line = aln_entries;
            head_rd   = '0;
            head_rem  = aln_n;
        end
    end

    // Push as many head entries as the IB has room for; flush pushes nothing
    always_comb begin
        push_cnt = '0;
        if (!flush) begin
            if (32'(ib_free) >= 32'(head_rem)) begin
                push_cnt = head_rem;
            end else begin
                push_cnt = PW'(ib_free);
            end
        end
    end

    assign push_num = push_cnt;

    // Present head entries starting at the oldest unpushed one
    always_comb begin
        push_data = '0;
        rd_idx    = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            rd_idx = head_rd + PW'(i);
            if (rd_idx < PW'(FETCH_WIDTH)) begin
                push_data[i*ENTRY_W +: ENTRY_W] =
                    head_line[int'(rd_idx[OW-1:0])*ENTRY_W +: ENTRY_W];
            end
        end
    end

    // Skid bookkeeping: pop a drained head, capture any unpushed response
    always_comb begin
        pop    = skid_ne && !flush && (push_cnt == head_rem);
        wr     = resp_take && (skid_ne || (aln_n > push_cnt));
        wr_rd  = skid_ne ? '0 : push_cnt;
        wr_cnt = skid_ne ? aln_n : (aln_n - push_cnt);
        occ_d  = occ_q + OCW'(wr) - OCW'(pop);
    end

    // A new request needs a skid line guaranteed free for its response
    always_comb begin
        req_ready = ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && resp_valid))
                    && (32'(occ_d) < SKID_LINES) && !flush;
    end

    assign accept = req_valid && req_ready;

    // Skid buffer storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hd_q  <= '0;
            tl_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < SKID_LINES; i++) begin
                skid_line_q[i] <= '0;
                skid_cnt_q[i]  <= '0;
                skid_rd_q[i]   <= '0;
            end
        end else if (flush) begin
            hd_q  <= '0;
            tl_q  <= '0;
            occ_q <= '0;
        end else begin
            if (skid_ne) begin
                if (pop) begin
                    hd_q <= (hd_q == SW'(SKID_LINES - 1)) ? '0 : hd_q + SW'(1);
                end else begin
                    skid_rd_q[hd_q]  <= head_rd + push_cnt;
                    skid_cnt_q[hd_q] <= head_rem - push_cnt;
                end
            end
            if (wr) begin
                skid_line_q[tl_q] <= aln_entries;
                skid_rd_q[tl_q]   <= wr_rd;
                skid_cnt_q[tl_q]  <= wr_cnt;
                tl_q <= (tl_q == SW'(SKID_LINES - 1)) ? '0 : tl_q + SW'(1);
            end
            occ_q <= occ_d;
        end
    end

    // Request controller and metadata capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            vmask_q <= '0;
            jmask_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (flush) begin
                        state_q <= resp_valid ? ST_IDLE : ST_DRAIN;
                    end else if (resp_valid) begin
                        state_q <= accept ? ST_WAIT : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (resp_valid) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (accept) begin
                pc_q    <= req_pc;
                vmask_q <= req_vmask;
                jmask_q <= req_jmask;
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_buf.sv
// Directed bench for fetch_align_buf (FETCH_WIDTH=4, IB depth 16, 2 skid lines).
// Instruction word at address A is A ^ 32'hC0DE_0000 so expected entries
// follow directly from the PC.
module tb_fetch_align_buf;
    import fetch_pkg::*;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_pc;
    logic [3:0]   req_vmask;
    logic [3:0]   req_jmask;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic [4:0]   ib_free;
    logic [2:0]   push_num;
    logic [263:0] push_data;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    fetch_align_buf #(
        .FETCH_WIDTH   (4),
        .IB_WIDTH_LOG2 (4),
        .SKID_LINES    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .req_vmask  (req_vmask),
        .req_jmask  (req_jmask),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .ib_free    (ib_free),
        .push_num   (push_num),
        .push_data  (push_data),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ent(input string tag, input int i, input logic v, input logic j,
                           input logic [31:0] pc);
        logic [65:0] exp;
        exp = {v, j, pc, pc ^ 32'hC0DE_0000};
        chk(tag, push_data[i*66 +: 66], exp);
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] pc);
        logic [127:0] d;
        logic [31:0]  base;
        base = pc & 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) begin
            d[k*32 +: 32] = (base + 32'(4 * k)) ^ 32'hC0DE_0000;
        end
        return d;
    endfunction

    // Move to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle mid-cycle
    task automatic settle();
        #3;
    endtask

    // Present one request for a single cycle and confirm the controller waits
    task automatic request(input string tag, input logic [31:0] pc,
                           input logic [3:0] vm, input logic [3:0] jm);
        req_valid = 1'b1;
        req_pc    = pc;
        req_vmask = vm;
        req_jmask = jm;
        settle();
        chk({tag, "_ready"}, req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        settle();
        chk({tag, "_wait"}, dbg_state, ST_WAIT);
        chk({tag, "_nopush"}, push_num, 0);
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_pc     = '0;
        req_vmask  = 4'hF;
        req_jmask  = 4'h0;
        resp_valid = 1'b0;
        resp_data  = '0;
        ib_free    = 5'd16;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        chk("rst_push", push_num, 0);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_state", dbg_state, ST_IDLE);

        // Misaligned PC: only words 2,3 of the line, bypassed the same cycle
        tick();
        request("mis", 32'h1008, 4'hF, 4'h0);
        tick();
        resp_valid = 1'b1;
        resp_data  = line_of(32'h1008);
        settle();
        chk("mis_num", push_num, 3'd2);
        chk_ent("mis_e0", 0, 1'b1, 1'b0, 32'h1008);
        chk_ent("mis_e1", 1, 1'b1, 1'b0, 32'h100C);
        tick();
        resp_valid = 1'b0;
        settle();
        chk("mis_after", push_num, 0);
        chk("mis_idle", dbg_state, ST_IDLE);

        // Taken jump in word 1 truncates the line
        tick();
        request("jmp", 32'h2000, 4'hF, 4'b0010);
        tick();
        resp_valid = 1'b1;
        resp_data  = line_of(32'h2000);
        settle();
        chk("jmp_num", push_num, 3'd2);
        chk_ent("jmp_e0", 0, 1'b1, 1'b0, 32'h2000);
        chk_ent("jmp_e1", 1, 1'b1, 1'b1, 32'h2004);
        tick();
        resp_valid = 1'b0;
        settle();
        chk("jmp_after", push_num, 0);

        // Partial push: 1 now, IB full for a cycle, then the remaining 3
        tick();
        request("part", 32'h3000, 4'hF, 4'h0);
        tick();
        resp_valid = 1'b1;
        resp_data  = line_of(32'h3000);
        ib_free    = 5'd1;
        settle();
        chk("part_num1", push_num, 3'd1);
        chk_ent("part_e0", 0, 1'b1, 1'b0, 32'h3000);
        tick();
        resp_valid = 1'b0;
        ib_free    = 5'd0;
        settle();
        chk("part_full", push_num, 0);
        tick();
        ib_free = 5'd3;
        settle();
        chk("part_num3", push_num, 3'd3);
        chk_ent("part_e0b", 0, 1'b1, 1'b0, 32'h3004);
        chk_ent("part_e1b", 1, 1'b1, 1'b0, 32'h3008);
        chk_ent("part_e2b", 2, 1'b1, 1'b0, 32'h300C);
        tick();
        ib_free = 5'd16;
        settle();
        chk("part_done", push_num, 0);

        // Valid mask carried per slot, jump in the last word
        tick();
        request("vm", 32'h7004, 4'b1011, 4'b1000);
        tick();
        resp_valid = 1'b1;
        resp_data  = line_of(32'h7004);
        settle();
        chk("vm_num", push_num, 3'd3);
        chk_ent("vm_e0", 0, 1'b1, 1'b0, 32'h7004);
        chk_ent("vm_e1", 1, 1'b0, 1'b0, 32'h7008);
        chk_ent("vm_e2", 2, 1'b1, 1'b1, 32'h700C);
        tick();
        resp_valid = 1'b0;

        // Flush while waiting: response is drained and dropped
        tick();
        request("fl", 32'h5000, 4'hF, 4'h0);
        flush = 1'b1;
        settle();
        chk("fl_ready", req_ready, 1'b0);
        chk("fl_push", push_num, 0);
        tick();
        flush = 1'b0;
        settle();
        chk("fl_drain", dbg_state, ST_DRAIN);
        chk("fl_drain_ready", req_ready, 1'b0);
        tick();
        resp_valid = 1'b1;
        resp_data  = line_of(32'h5000);
        settle();
        chk("fl_resp_push", push_num, 0);
        tick();
        resp_valid = 1'b0;
        settle();
        chk("fl_idle", dbg_state, ST_IDLE);
        chk("fl_ready_back", req_ready, 1'b1);
        chk("fl_after_push", push_num, 0);

        // Back-to-back lines with the IB full: skid fills, then drains in order
        tick();
        ib_free = 5'd0;
        request("b2b", 32'h4000, 4'hF, 4'h0);
        tick();
        resp_valid = 1'b1;
        resp_data  = line_of(32'h4000);
        req_valid  = 1'b1;
        req_pc     = 32'h4010;
        req_vmask  = 4'hF;
        req_jmask  = 4'h0;
        settle();
        chk("b2b_ready2", req_ready, 1'b1);
        chk("b2b_push1", push_num, 0);
        tick();
        req_valid = 1'b0;
        resp_data = line_of(32'h4010);
        settle();
        chk("b2b_push2", push_num, 0);
        chk("b2b_full_ready", req_ready, 1'b0);
        tick();
        resp_valid = 1'b0;
        settle();
        chk("b2b_hold_ready", req_ready, 1'b0);
        chk("b2b_hold_push", push_num, 0);
        tick();
        ib_free = 5'd16;
        settle();
        chk("b2b_num_a", push_num, 3'd4);
        chk_ent("b2b_a0", 0, 1'b1, 1'b0, 32'h4000);
        chk_ent("b2b_a3", 3, 1'b1, 1'b0, 32'h400C);
        tick();
        settle();
        chk("b2b_num_b", push_num, 3'd4);
        chk_ent("b2b_b0", 0, 1'b1, 1'b0, 32'h4010);
        chk_ent("b2b_b3", 3, 1'b1, 1'b0, 32'h401C);
        tick();
        settle();
        chk("b2b_empty", push_num, 0);
        chk("b2b_ready_back", req_ready, 1'b1);

        // Reset while waiting: a late response must be ignored
        tick();
        request("rw", 32'h6000, 4'hF, 4'h0);
        rst = 1'b1;
        #1;
        chk("rw_state", dbg_state, ST_IDLE);
        chk("rw_push", push_num, 0);
        tick();
        rst = 1'b0;
        tick();
        resp_valid = 1'b1;
        resp_data  = line_of(32'h6000);
        settle();
        chk("rw_late_push", push_num, 0);
        chk("rw_late_ready", req_ready, 1'b1);
        tick();
        resp_valid = 1'b0;
        settle();
        chk("rw_after_state", dbg_state, ST_IDLE);
        chk("rw_after_push", push_num, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
